// File: rtl/gameover_screen_ctrl.sv
// ---------------------------------------------------------------------------
// gameover_screen_ctrl
//
// Overlays a game-over image (IMG_W x IMG_H, 8-bit pixels, external ROM) onto
// a raster at (X0, Y0). The image is hidden, revealed top-down one band of
// WIPE_STEP rows per frame, or fully shown.
//
// Optional feature macro: GOVR_WIPE_EN
//   defined   : HIDDEN -> WIPE -> SHOWN, with a 9-bit reveal counter.
//   undefined : HIDDEN -> SHOWN directly; no reveal logic exists.
//
// Ports
//   i_clk2      clock, shared with the image ROM
//   i_rst       synchronous active-high reset
//   i_x, i_y    current screen column / row (10 bits each)
//   i_de        display enable for i_x/i_y
//   i_frame     one-cycle pulse at start of frame
//   i_show      one-cycle request to display the image
//   i_clear     one-cycle request to hide the image (wins over i_show)
//   o_addr      registered ROM address, 0 outside the image window
//   i_rom_data  ROM pixel, valid one cycle after o_addr
//   o_pixel     output pixel, 2 cycles after i_x/i_y/i_de
//   o_de        i_de delayed to align with o_pixel
//   o_state     0 HIDDEN, 1 WIPE, 2 SHOWN
// ---------------------------------------------------------------------------
module gameover_screen_ctrl #(
    parameter int         X0        = 80,
    parameter int         Y0        = 60,
    parameter int         IMG_W     = 480,
    parameter int         IMG_H     = 360,
    parameter logic [7:0] BG        = 8'h00,
    parameter int         WIPE_STEP = 8
) (
    input  logic        i_clk2,
    input  logic        i_rst,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_de,
    input  logic        i_frame,
    input  logic        i_show,
    input  logic        i_clear,
    output logic [17:0] o_addr,
    input  logic [7:0]  i_rom_data,
    output logic [7:0]  o_pixel,
    output logic        o_de,
    output logic [1:0]  o_state
);

    localparam logic [9:0]  X_LO     = 10'(X0);
    localparam logic [9:0]  X_HI     = 10'(X0 + IMG_W - 1);
    localparam logic [9:0]  Y_LO     = 10'(Y0);
    localparam logic [9:0]  Y_HI     = 10'(Y0 + IMG_H - 1);
    localparam logic [17:0] ROW_STEP = 18'(IMG_W);

    // A zero or oversize step would stall the wipe or skip rows.
    if (WIPE_STEP < 1 || WIPE_STEP > IMG_H) begin : g_bad_step
        $error("gameover_screen_ctrl: WIPE_STEP out of range");
    end

    typedef enum logic [1:0] {
        ST_HIDDEN = 2'd0,
        ST_WIPE   = 2'd1,
        ST_SHOWN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_vis;

    // -----------------------------------------------------------------------
    // Visibility FSM
    // -----------------------------------------------------------------------
`ifdef GOVR_WIPE_EN
    localparam logic [9:0] STEP10 = 10'(WIPE_STEP);
    localparam logic [9:0] H10    = 10'(IMG_H);

    logic [8:0] r_reveal;
    logic [8:0] w_reveal_nxt;
    logic [9:0] w_rev_sum;
    logic [9:0] w_row;

    // One bit of headroom so the saturation test cannot wrap.
    assign w_rev_sum = {1'b0, r_reveal} + STEP10;
    assign w_row     = i_y - Y_LO;

    always_comb begin
        w_state_nxt  = r_state;
        w_reveal_nxt = r_reveal;
        if (i_clear) begin
            w_state_nxt  = ST_HIDDEN;
            w_reveal_nxt = '0;
        end else begin
            case (r_state)
                ST_HIDDEN: begin
                    if (i_show) begin
                        w_state_nxt  = ST_WIPE;
                        w_reveal_nxt = '0;
                    end
                end
                ST_WIPE: begin
                    if (i_frame) begin
                        if (w_rev_sum >= H10) begin
                            w_state_nxt  = ST_SHOWN;
                            w_reveal_nxt = H10[8:0];
                        end else begin
                            w_reveal_nxt = w_rev_sum[8:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            r_state  <= ST_HIDDEN;
            r_reveal <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_reveal <= w_reveal_nxt;
        end
    end

    // Rows above Y0 give a wrapped w_row; the window flag masks them.
    assign w_vis = (r_state == ST_SHOWN) ||
                   ((r_state == ST_WIPE) && (w_row < {1'b0, r_reveal}));
`else
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_HIDDEN;
        end else if (r_state == ST_HIDDEN && i_show) begin
            w_state_nxt = ST_SHOWN;
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            r_state <= ST_HIDDEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_vis = (r_state == ST_SHOWN);
`endif

    assign o_state = r_state;

    // -----------------------------------------------------------------------
    // Row-base accumulator: r_base is the address of column X0 on row
    // r_last_y. Rows at or above Y0 restart it at 0; each step of i_y by one
    // inside the image adds IMG_W. Any other jump holds the base, so the
    // raster must advance row by row. Not reset: it is a pure function of
    // the i_y stream and must stay in step with a frame already in progress.
    // -----------------------------------------------------------------------
    logic [9:0]  r_last_y;
    logic [17:0] r_base;
    logic [17:0] w_base;
    logic [9:0]  w_col;
    logic [17:0] w_addr;
    logic        w_in_win;

    always_comb begin
        w_base = r_base;
        if (i_y <= Y_LO) begin
            w_base = '0;
        end else if ((i_y == r_last_y + 10'd1) && (i_y <= Y_HI)) begin
            w_base = r_base + ROW_STEP;
        end
    end

    always_ff @(posedge i_clk2) begin
        r_last_y <= i_y;
        r_base   <= w_base;
    end

    assign w_in_win = (i_x >= X_LO) && (i_x <= X_HI) &&
                      (i_y >= Y_LO) && (i_y <= Y_HI);
    assign w_col    = i_x - X_LO;
    assign w_addr   = w_base + {8'd0, w_col};

    // -----------------------------------------------------------------------
    // Two-stage flag pipeline: stage 0 -> [0] alongside o_addr, [1] alongside
    // the ROM data returned for that address.
    // -----------------------------------------------------------------------
    logic [1:0] r_de_pipe;
    logic [1:0] r_win_pipe;
    logic [1:0] r_vis_pipe;

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            o_addr     <= '0;
            r_de_pipe  <= '0;
            r_win_pipe <= '0;
            r_vis_pipe <= '0;
        end else begin
            o_addr     <= w_in_win ? w_addr : 18'd0;
            r_de_pipe  <= {r_de_pipe[0], i_de};
            r_win_pipe <= {r_win_pipe[0], w_in_win};
            r_vis_pipe <= {r_vis_pipe[0], w_vis};
        end
    end

    assign o_de    = r_de_pipe[1];
    assign o_pixel = (r_de_pipe[1] && r_win_pipe[1] && r_vis_pipe[1]) ?
                     i_rom_data : BG;

endmodule

// File: tb/tb_gameover_screen_ctrl.sv
module tb_gameover_screen_ctrl;

    logic        i_clk2 = 1'b0;
    logic        i_rst;
    logic [9:0]  i_x;
    logic [9:0]  i_y;
    logic        i_de;
    logic        i_frame;
    logic        i_show;
    logic        i_clear;
    logic [17:0] o_addr;
    logic [7:0]  i_rom_data;
    logic [7:0]  o_pixel;
    logic        o_de;
    logic [1:0]  o_state;

    int n_chk  = 0;
    int n_pass = 0;

    gameover_screen_ctrl dut (
        .i_clk2     (i_clk2),
        .i_rst      (i_rst),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_de       (i_de),
        .i_frame    (i_frame),
        .i_show     (i_show),
        .i_clear    (i_clear),
        .o_addr     (o_addr),
        .i_rom_data (i_rom_data),
        .o_pixel    (o_pixel),
        .o_de       (o_de),
        .o_state    (o_state)
    );

    always #5 i_clk2 = ~i_clk2;

    function automatic logic [7:0] romf(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'hA5;
    endfunction

    // Synchronous ROM model: data one cycle after the address.
    always @(posedge i_clk2) i_rom_data <= romf(o_addr);

    task automatic tick();
        @(posedge i_clk2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Walk i_y one row at a time (the address generator tracks rows).
    task automatic goto_row(input int y);
        i_de = 1'b0;
        i_x  = 10'd0;
        if (y < int'(i_y)) begin
            i_y = 10'd0;
            tick();
        end
        while (int'(i_y) < y) begin
            i_y = i_y + 10'd1;
            tick();
        end
    endtask

    // Drive one pixel, check o_addr after 1 cycle and o_pixel/o_de after 2.
    task automatic pix(input string tag, input int x, input int y, input bit vis);
        bit          inwin;
        logic [17:0] ea;
        goto_row(y);
        inwin = (x >= 80) && (x <= 559) && (y >= 60) && (y <= 419);
        ea    = inwin ? 18'((y - 60) * 480 + (x - 80)) : 18'd0;
        i_x   = 10'(x);
        i_de  = 1'b1;
        tick();
        chk({tag, "_addr"}, 32'(o_addr), 32'(ea));
        i_x  = 10'd0;
        i_de = 1'b0;
        tick();
        chk({tag, "_pix"}, 32'(o_pixel), (inwin && vis) ? 32'(romf(ea)) : 32'h00);
        chk({tag, "_de"}, 32'(o_de), 32'd1);
    endtask

    task automatic pulse_frame();
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
    endtask

    initial begin
        int xs[5];
        xs = '{0, 80, 300, 559, 639};
        i_rst = 1'b1; i_x = '0; i_y = '0; i_de = 1'b0;
        i_frame = 1'b0; i_show = 1'b0; i_clear = 1'b0;
        tick(); tick(); tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_addr",  32'(o_addr),  32'd0);
        chk("rst_pixel", 32'(o_pixel), 32'h00);
        chk("rst_de",    32'(o_de),    32'd0);
        i_rst = 1'b0;
        tick();

        // Sparse full-height scan with nothing shown: always background.
        for (int y = 0; y < 480; y++) begin
            goto_row(y);
            for (int k = 0; k < 5; k++) begin
                i_x  = 10'(xs[k]);
                i_de = 1'b1;
                tick();
                chk("blank_px", 32'(o_pixel), 32'h00);
            end
        end
        chk("blank_state", 32'(o_state), 32'd0);
        pix("hidden_mid", 300, 200, 1'b0);

        i_show = 1'b1;
        tick();
        i_show = 1'b0;
`ifdef GOVR_WIPE_EN
        chk("show_wipe", 32'(o_state), 32'd1);
        pix("wipe0_row60", 100, 60, 1'b0);
        pulse_frame(); pulse_frame(); pulse_frame();
        pix("reveal24_row83", 100, 83, 1'b1);
        pix("reveal24_row84", 100, 84, 1'b0);
        i_show = 1'b1;
        tick();
        i_show = 1'b0;
        chk("show_in_wipe", 32'(o_state), 32'd1);
        for (int f = 4; f < 45; f++) pulse_frame();
        chk("wipe_44", 32'(o_state), 32'd1);
        pulse_frame();
        chk("wipe_45", 32'(o_state), 32'd2);
`else
        chk("show_direct", 32'(o_state), 32'd2);
`endif

        pix("tl",        80,  60, 1'b1);
        pix("left_out",  79,  60, 1'b1);
        pix("mid",       300, 200, 1'b1);
        pix("br",        559, 419, 1'b1);
        pix("right_out", 560, 419, 1'b1);

        i_show = 1'b1;
        tick();
        i_show = 1'b0;
        chk("show_ignored", 32'(o_state), 32'd2);

        i_show  = 1'b1;
        i_clear = 1'b1;
        tick();
        i_show  = 1'b0;
        i_clear = 1'b0;
        chk("clear_wins", 32'(o_state), 32'd0);
        pix("after_clear", 300, 200, 1'b0);

        // Reset mid-line with image pixels in flight.
        i_show = 1'b1;
        tick();
        i_show = 1'b0;
`ifdef GOVR_WIPE_EN
        pulse_frame(); pulse_frame(); pulse_frame();
        chk("rewipe_state", 32'(o_state), 32'd1);
`endif
        pix("pre_rst_row70", 100, 70, 1'b1);
        i_x  = 10'd101;
        i_de = 1'b1;
        tick();
        i_x   = 10'd102;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst_state", 32'(o_state), 32'd0);
        chk("midrst_pixel", 32'(o_pixel), 32'h00);
        chk("midrst_de",    32'(o_de),    32'd0);
        chk("midrst_addr",  32'(o_addr),  32'd0);
        i_x = 10'd103;
        tick();
        chk("midrst_pixel1", 32'(o_pixel), 32'h00);
        i_de = 1'b0;
        tick();
        chk("midrst_pixel2", 32'(o_pixel), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gameover_screen_ctrl.md
GAMEOVER_SCREEN_CTRL -- requirements
Module: gameover_screen_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- X0, 80: image left edge, screen column.
- Y0, 60: image top edge, screen row.
- IMG_W, 480: image width in pixels.
- IMG_H, 360: image height in pixels.
- BG, 8'h00: background pixel value outside the image or when hidden.
- WIPE_STEP, 8: rows revealed per frame during wipe.
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk2, in, 1: single clock, shared with the image ROM.
- i_rst, in, 1: synchronous, active-high reset.
- i_x, in, 10: current screen column, 0..639.
- i_y, in, 10: current screen row, 0..479.
- i_de, in, 1: display enable for i_x/i_y.
- i_frame, in, 1: one-cycle pulse at start of frame.
- i_show, in, 1: one-cycle request to display game-over image.
- i_clear, in, 1: one-cycle request to hide the image.
- o_addr, out, 18: ROM address, 0..172799.
- i_rom_data, in, 8: ROM pixel; valid one cycle after o_addr.
- o_pixel, out, 8: output pixel.
- o_de, out, 1: i_de delayed to align with o_pixel.
- o_state, out, 2: 0 HIDDEN, 1 WIPE, 2 SHOWN.

Function
REQ-003 The block SHALL register o_addr = (i_y-Y0)*IMG_W + (i_x-X0) when i_x in [X0, X0+IMG_W-1] and i_y in [Y0, Y0+IMG_H-1], else hold o_addr at 0.
REQ-004 The block SHALL compute o_addr with a registered row-base accumulator (+IMG_W per image row), with no multiplier.
REQ-005 o_pixel and o_de SHALL lag i_x/i_y/i_de by exactly 2 cycles; the in-window flag and the visibility flag SHALL be piped through 2 matching stages.
REQ-006 o_pixel SHALL equal i_rom_data when delayed de=1, in-window=1 and row visible; otherwise BG.
REQ-007 Row visibility: HIDDEN none; SHOWN all; WIPE rows with (i_y-Y0) < reveal, where reveal is a 9-bit counter.
REQ-008 FSM transitions: HIDDEN -> WIPE on i_show, reveal := 0; WIPE: reveal += WIPE_STEP on each i_frame, saturating at IMG_H; WIPE -> SHOWN on the i_frame where reveal would reach or exceed IMG_H; any state -> HIDDEN on i_clear.
REQ-009 i_clear and i_show in the same cycle SHALL result in HIDDEN (clear wins).
REQ-010 i_show in WIPE or SHOWN SHALL be ignored; it does not restart the wipe.
REQ-011 State and reveal changes SHALL take effect on the next cycle; a frame already in progress uses the new value from the following pixel onward.
REQ-012 Counters SHALL never exceed range: o_addr <= IMG_W*IMG_H-1 and reveal <= IMG_H.

Reset
REQ-013 When i_rst=1 at a clock edge: state HIDDEN, reveal 0, o_addr 0, o_pixel BG, o_de 0, all pipeline flags 0.
REQ-014 Reset mid-wipe or mid-line SHALL abort immediately, with no residual image pixels after the pipeline drains (2 cycles).

Configuration
REQ-015 Macro GOVR_WIPE_EN: when defined, the WIPE state and reveal counter SHALL exist per REQ-007/008.
REQ-016 When GOVR_WIPE_EN is undefined, i_show SHALL go HIDDEN -> SHOWN directly, o_state SHALL never read 1, and no reveal logic SHALL be synthesized.

Verification
REQ-017 Scenarios a bench must cover:
- Reset, then a full frame with no i_show -> every o_pixel = 8'h00, o_state = 0.
- i_show, then 45 frames (WIPE_EN) -> o_state = 2 after the 45th i_frame; pixel (80,60) yields o_addr 0 and o_pixel = ROM[0] 2 cycles later.
- SHOWN, pixel (559,419) -> o_addr 172799; pixel (560,419) and (79,60) -> o_pixel = BG.
- WIPE after 3 i_frame pulses (reveal = 24) -> row 83 shows ROM data and row 84 shows BG.
- i_show and i_clear in the same cycle while SHOWN -> o_state = 0 next cycle.
- i_rst asserted mid-line during WIPE -> o_state = 0 next cycle and o_pixel = BG within 2 cycles.
